// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the buffered N-way multiplexer:
//   - MUX_DEFAULT_WIDTH : default data width of each mux input (32)
//   - clog2()           : constant ceil(log2()) usable in parameter expressions
//   - sel_width()       : max(1, clog2(n)), width of a select or pointer
//                         that must index n items
//   - fifo_op_e         : encoding of the {push, pop} pair seen at a clock edge
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam int unsigned MUX_DEFAULT_WIDTH = 32;

  // ceil(log2(value)); clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  // A select (or pointer) always has at least one bit, even for n <= 2.
  function automatic int unsigned sel_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // {push, pop} happening on the same rising edge.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage : mux_pkg

// File: rtl/mux_n_comb.sv
// -----------------------------------------------------------------------------
// mux_n_comb
// Purely combinational NUM_IN:1 selector. Input i is in_bus[i*WIDTH +: WIDTH].
// A select value that names no input (sel >= NUM_IN, possible whenever NUM_IN
// is not a power of two) yields an all-zero output.
//
// Parameters:
//   WIDTH   data width of each input and of the output
//   NUM_IN  number of selectable inputs (>= 2)
//   SEL_W   derived select width, max(1, clog2(NUM_IN)); not overridable
// Ports:
//   sel     input  [SEL_W-1:0]         input select
//   in_bus  input  [NUM_IN*WIDTH-1:0]  packed inputs
//   dout    output [WIDTH-1:0]         selected input, or 0 when out of range
// -----------------------------------------------------------------------------
module mux_n_comb
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH  = MUX_DEFAULT_WIDTH,
  parameter  int unsigned NUM_IN = 4,
  localparam int unsigned SEL_W  = sel_width(NUM_IN)
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  output logic [WIDTH-1:0]        dout
);

  // A compare-per-input loop rather than an indexed part-select: an
  // out-of-range select simply matches nothing and leaves the zero default.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would infer a latch.
    dout = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        dout = in_bus[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule : mux_n_comb

// File: rtl/mux_n_buffered.sv
// -----------------------------------------------------------------------------
// mux_n_buffered
// N-way, WIDTH-bit multiplexer whose result is captured into a DEPTH-entry
// FIFO together with the select that produced it. A valid/ready handshake on
// each side lets the datapath hold a selected operand across stall cycles.
//
// Build option:
//   MUX_SEL_CHECK_EN  when defined, adds the sticky sel_err output, set by any
//                     accepted transfer whose Src >= NUM_IN. The data path is
//                     identical with or without it.
//
// Parameters:
//   WIDTH   data width (default 32)
//   NUM_IN  number of inputs (>= 2, any value)
//   DEPTH   FIFO depth in entries (>= 1, any value)
//   SEL_W   derived select width, max(1, clog2(NUM_IN)); not overridable
// Ports:
//   CLK        input   rising-edge clock
//   RST_n      input   synchronous active-low reset
//   flush      input   synchronous clear of all buffered entries
//   Src        input   [SEL_W-1:0] select, sampled on accept
//   in_bus     input   [NUM_IN*WIDTH-1:0] packed inputs
//   in_valid   input   producer offers a selection
//   in_ready   output  FIFO has room (depends on registered count only)
//   out        output  [WIDTH-1:0] head entry data, 0 when empty
//   out_src    output  [SEL_W-1:0] head entry select, 0 when empty
//   out_valid  output  FIFO not empty
//   out_ready  input   consumer takes the head entry
//   sel_err    output  sticky out-of-range select flag (MUX_SEL_CHECK_EN only)
// -----------------------------------------------------------------------------
module mux_n_buffered
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH  = MUX_DEFAULT_WIDTH,
  parameter  int unsigned NUM_IN = 4,
  parameter  int unsigned DEPTH  = 2,
  localparam int unsigned SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic                    flush,
  input  logic [SEL_W-1:0]        Src,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_SEL_CHECK_EN
  ,
  output logic                    sel_err
`endif
);

  localparam int unsigned PTR_W = sel_width(DEPTH);
  // The count must reach DEPTH itself, hence DEPTH+1 distinct values.
  localparam int unsigned CNT_W = sel_width(DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Select
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sel_data;

  mux_n_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .sel    (Src),
    .in_bus (in_bus),
    .dout   (sel_data)
  );

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [SEL_W-1:0] mem_src  [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic     push_fire;
  logic     pop_fire;
  fifo_op_e op;

  // Explicit wrap compare so a non-power-of-two DEPTH still cycles through
  // exactly DEPTH slots.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // in_ready looks only at the registered count, never at out_ready: a full
  // FIFO refuses input even on a cycle where the head is being popped.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push_fire = in_valid && in_ready;
  assign pop_fire  = out_valid && out_ready;
  assign op        = fifo_op_e'({push_fire, pop_fire});

  always_ff @(posedge CLK) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (!RST_n || flush) begin
      // Reset and flush both empty the FIFO and override any push/pop that
      // coincides with them.
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          count  <= count + CNT_W'(1);
          wr_ptr <= ptr_inc(wr_ptr);
        end
        OP_POP: begin
          count  <= count - CNT_W'(1);
          rd_ptr <= ptr_inc(rd_ptr);
        end
        OP_BOTH: begin
          wr_ptr <= ptr_inc(wr_ptr);
          rd_ptr <= ptr_inc(rd_ptr);
        end
        default: ;
      endcase
    end
  end

  // NOTE: the storage array carries no reset; out/out_src are masked to zero
  // while empty, so stale or uninitialised entries are never observable.
  always_ff @(posedge CLK) begin
    if (RST_n && !flush && push_fire) begin
      mem_data[wr_ptr] <= sel_data;
      mem_src[wr_ptr]  <= Src;
    end
  end

  assign out     = out_valid ? mem_data[rd_ptr] : '0;
  assign out_src = out_valid ? mem_src[rd_ptr]  : '0;

  // ---------------------------------------------------------------------------
  // Optional out-of-range select monitor
  // ---------------------------------------------------------------------------
`ifdef MUX_SEL_CHECK_EN
  logic sel_oob;

  assign sel_oob = (32'(Src) >= NUM_IN);

  // Flush clears the flag even if an out-of-range transfer arrives that edge;
  // such a transfer is discarded by the flush anyway.
  always_ff @(posedge CLK) begin
    if (!RST_n || flush) begin
      sel_err <= 1'b0;
    end else if (push_fire && sel_oob) begin
      sel_err <= 1'b1;
    end
  end
`endif

endmodule : mux_n_buffered
